// File: rtl/btn_event.sv
// Button event decoder: turns a debounced level into press/release/click/double-click/long-press pulses.
// Define BTN_EVENT_REPEAT_EN to enable auto-repeat; release/repeat are SV keywords, hence the _evt port names.
module btn_event #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int DCLICK_CYCLES = 12500000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press,
  output logic release_evt,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam int MAX_AB  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {IDLE, PRESSED, WAIT2, PRESSED2, LONG} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          level_q;
  logic          rise, fall;
  logic          timer_clr;
  logic          press_d, release_d, click_d, dclick_d, long_d;
`ifdef BTN_EVENT_REPEAT_EN
  logic          repeat_d;
`endif

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;
  assign held = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      level_q     <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      click       <= 1'b0;
      dclick      <= 1'b0;
      long_press  <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
      repeat_evt  <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      level_q     <= level;
      press       <= press_d;
      release_evt <= release_d;
      click       <= click_d;
      dclick      <= dclick_d;
      long_press  <= long_d;
`ifdef BTN_EVENT_REPEAT_EN
      repeat_evt  <= repeat_d;
`endif
      if (timer_clr)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + TW'(1);
    end
  end

`ifndef BTN_EVENT_REPEAT_EN
  assign repeat_evt = 1'b0;
`endif

  // Level edges are tested before timer thresholds so an edge always wins a tie.
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    case (state)
      IDLE:     if (rise) state_next = PRESSED;
      PRESSED:  if (fall) state_next = WAIT2;
                else if (timer == LONG_LAST) state_next = LONG;
      WAIT2:    if (rise) state_next = PRESSED2;
                else if (timer == DCLICK_LAST) state_next = IDLE;
      PRESSED2: if (fall) state_next = IDLE;
                else if (timer == LONG_LAST) state_next = LONG;
      LONG: begin
        if (fall) state_next = IDLE;
`ifdef BTN_EVENT_REPEAT_EN
        else if (timer == REPEAT_LAST) timer_clr = 1'b1;
`endif
      end
      default:  state_next = IDLE;
    endcase
    if (state_next != state)
      timer_clr = 1'b1;
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state)
      IDLE:     press_d = rise;
      PRESSED:  if (fall) release_d = 1'b1;
                else if (timer == LONG_LAST) long_d = 1'b1;
      WAIT2:    if (rise) press_d = 1'b1;
                else if (timer == DCLICK_LAST) click_d = 1'b1;
      PRESSED2: begin
        if (fall) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
        end else if (timer == LONG_LAST) begin
          long_d = 1'b1;
        end
      end
      LONG: begin
        if (fall) release_d = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
        else if (timer == REPEAT_LAST) repeat_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 25000000, hold time in clk cycles before a long press (>=2).
REQ-002 SHALL have parameter DCLICK_CYCLES, default 12500000, maximum release-to-press gap in clk cycles for a double click (>=2).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5000000, auto-repeat period in clk cycles (>=2).
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 level  input  1  debounced button level from the debouncer, already synchronous to clk; 1 = pressed.
REQ-007 press  output  1  single-cycle pulse on press.
REQ-008 release  output  1  single-cycle pulse on release.
REQ-009 click  output  1  single-cycle pulse on a completed single short click.
REQ-010 dclick  output  1  single-cycle pulse on a completed double click.
REQ-011 long_press  output  1  single-cycle pulse when the hold reaches LONG_CYCLES.
REQ-012 repeat  output  1  single-cycle auto-repeat pulse while long-held.
REQ-013 held  output  1  registered copy of level.

Function
REQ-014 SHALL register level into level_q each cycle; rise = level & ~level_q; fall = ~level & level_q; held = level_q.
REQ-015 SHALL register all pulse outputs; each pulse is high exactly one cycle, in the cycle after the clk edge that samples the causing condition (1-cycle latency).
REQ-016 SHALL keep a timer, wide enough for max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES); timer clears on every state change and otherwise increments, saturating at all-ones.
REQ-017 SHALL implement states IDLE, PRESSED, WAIT2, PRESSED2, LONG.
REQ-018 IDLE: rise -> PRESSED, pulse press.
REQ-019 PRESSED: fall -> WAIT2, pulse release; else timer == LONG_CYCLES-1 -> LONG, pulse long_press.
REQ-020 WAIT2: rise -> PRESSED2, pulse press; else timer == DCLICK_CYCLES-1 -> IDLE, pulse click.
REQ-021 PRESSED2: fall -> IDLE, pulse release and dclick in the same cycle; else timer == LONG_CYCLES-1 -> LONG, pulse long_press (no click/dclick for this sequence).
REQ-022 LONG: fall -> IDLE, pulse release; no click or dclick.
REQ-023 A level edge SHALL take precedence over a timer threshold in the same cycle.
REQ-024 A press after a long press or a double click SHALL start a fresh sequence from IDLE (no triple-click chaining).
REQ-025 click and dclick SHALL never both pulse for one sequence.

Reset
REQ-026 While rst_n is low: state IDLE, timer 0, level_q 0, all outputs 0, independent of clk.
REQ-027 Reset mid-sequence SHALL abandon it with no pending pulses; if level is high after reset release, press pulses one cycle after the first sampling edge.

Configuration
REQ-028 Macro BTN_EVENT_REPEAT_EN defined: in LONG, repeat pulses when timer == REPEAT_CYCLES-1, the timer then clears, giving a pulse every REPEAT_CYCLES cycles, first one REPEAT_CYCLES cycles after long_press; fall in the same cycle suppresses repeat.
REQ-029 Macro undefined: repeat port present, tied 0; LONG timer logic for repeat omitted; all other behaviour identical.

Verification (LONG_CYCLES=8, DCLICK_CYCLES=4, REPEAT_CYCLES=3)
REQ-030 level high 3 cycles, low 10 -> press, release, then click exactly 4 cycles after release pulse; no dclick/long_press.
REQ-031 high 3, low 2, high 3, low -> press, release, press, then release+dclick same cycle; no click.
REQ-032 high 20 cycles, macro defined -> press, long_press 8 cycles after press, repeat at +3, +6, +9...; release on fall; no click.
REQ-033 same stimulus, macro undefined -> identical except repeat stays 0.
REQ-034 fall in the exact cycle timer reaches 7 in PRESSED -> release, no long_press; click 4 cycles later.
REQ-035 rst_n low for 2 cycles while in WAIT2, level high at release -> all outputs 0 during reset, no click, press one cycle after first post-reset edge.
